alu_seq: RTL

//  Parametrised, multi-cycle successor to the single-cycle datapath ALU.

---
 rtl/alu_seq.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU, valid/ready in and out, iterative radix-2 Booth MUL
// Optional sticky overflow flag (of_sticky/of_clr) enabled by defining ALU_STICKY_OF_EN.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int MUL_W = 16
) (
`ifdef ALU_STICKY_OF_EN
    input  logic             of_clr,
    output logic             of_sticky,
`endif
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALU_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_result,
    output logic             OF
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(MUL_W + 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SLL = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [WIDTH-1:0]        result_q, result_d;
    logic                    of_q, of_d;
    logic [MUL_W:0]          acc_q, acc_d;
    logic [MUL_W:0]          m_q, m_d;
    logic [MUL_W-1:0]        mq_q, mq_d;
    logic                    q1_q, q1_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    logic [WIDTH-1:0]        sum, diff, alu_r;
    logic                    add_of, sub_of, alu_of;
    logic [SW-1:0]           shamt;
    logic [MUL_W:0]          acc_sum, acc_sh;
    logic [MUL_W-1:0]        mq_sh;
    logic signed [2*MUL_W-1:0] product;

    always_comb begin
        sum    = A + B;
        diff   = A - B;
        add_of = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
        sub_of = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
        shamt  = B[SW-1:0];
        alu_r  = '0;
        alu_of = 1'b0;
        case (ALU_sel)
            OP_AND: alu_r = A & B;
            OP_OR:  alu_r = A | B;
            OP_ADD: begin alu_r = sum;  alu_of = add_of; end
            OP_SLL: alu_r = A << shamt;
            OP_SRL: alu_r = A >> shamt;
            OP_SUB: begin alu_r = diff; alu_of = sub_of; end
            OP_SLT: alu_r = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            default: alu_r = '0;
        endcase
    end

    // Accumulator is one bit wider than M so that subtracting the most negative M cannot overflow.
    always_comb begin
        case ({mq_q[0], q1_q})
            2'b01:   acc_sum = acc_q + m_q;
            2'b10:   acc_sum = acc_q - m_q;
            default: acc_sum = acc_q;
        endcase
        acc_sh  = {acc_sum[MUL_W], acc_sum[MUL_W:1]};
        mq_sh   = {acc_sum[0], mq_q[MUL_W-1:1]};
        product = {acc_sh[MUL_W-1:0], mq_sh};
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        of_d      = of_q;
        acc_d     = acc_q;
        m_d       = m_q;
        mq_d      = mq_q;
        q1_d      = q1_q;
        cnt_d     = cnt_q;
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (ALU_sel == OP_MUL) begin
                        acc_d   = '0;
                        m_d     = {A[MUL_W-1], A[MUL_W-1:0]};
                        mq_d    = B[MUL_W-1:0];
                        q1_d    = 1'b0;
                        cnt_d   = CW'(MUL_W);
                        state_d = S_MUL;
                    end else begin
                        result_d = alu_r;
                        of_d     = alu_of;
                        state_d  = S_DONE;
                    end
                end
            end
            S_MUL: begin
                acc_d = acc_sh;
                mq_d  = mq_sh;
                q1_d  = mq_q[0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d = WIDTH'(product);
                    of_d     = 1'b0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            of_q     <= 1'b0;
            acc_q    <= '0;
            m_q      <= '0;
            mq_q     <= '0;
            q1_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            of_q     <= of_d;
            acc_q    <= acc_d;
            m_q      <= m_d;
            mq_q     <= mq_d;
            q1_q     <= q1_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ALU_result = result_q;
    assign OF         = of_q;

`ifdef ALU_STICKY_OF_EN
    logic sticky_q;

    // alu_of is only ever set for ADD/SUB, so an accepted op with alu_of means a completed overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else if ((state_q == S_IDLE) && in_valid && alu_of) begin
            sticky_q <= 1'b1;
        end else if (of_clr) begin
            sticky_q <= 1'b0;
        end
    end

    assign of_sticky = sticky_q;
`endif

endmodule
